// File: rtl/alu_pkg.sv
// Package: alu_pkg -- opcodes, FSM states and shared widths for alu_seq.
package alu_pkg;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_SLTU = 4'h6,
    OP_SLL  = 4'h7,
    OP_SRL  = 4'h8,
    OP_SRA  = 4'h9,
    OP_MUL  = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Flags that travel with every registered result.
  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic err;
  } alu_flags_t;
endpackage

// File: rtl/alu_seq_if.sv
// Interface: alu_seq_if -- operand/opcode request and result response of alu_seq.
interface alu_seq_if #(parameter int N = 8);
  import alu_pkg::*;

  logic                in_valid_i;
  logic                in_ready_o;
  logic [ALU_OP_W-1:0] sel_i;
  logic [N-1:0]        a_i;
  logic [N-1:0]        b_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [N-1:0]        s_o;
  logic                z_o;
  logic                c_o;
  logic                v_o;
  logic                err_o;

  modport master (
    output in_valid_i, sel_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, s_o, z_o, c_o, v_o, err_o
  );

  modport slave (
    input  in_valid_i, sel_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, s_o, z_o, c_o, v_o, err_o
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Module: alu_mul_iter -- unsigned shift-add multiplier, one step per cycle,
// N steps; only the low N product bits are kept. Built only with ALU_SEQ_MUL_EN.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] prod_o
);
  localparam int CW = $clog2(N+1);

  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Load operands on start, then one conditional add + shift per cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      cnt_d    = CW'(N);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      done_d   = (cnt_q == CW'(1));
    end
  end

  // Datapath registers; reset discards any partial product.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // done pulses the cycle after the last step, when acc holds the final product.
  assign done_o = done_q;
  assign prod_o = acc_q;
endmodule
`endif

// File: rtl/alu_seq.sv
// Module: alu_seq -- registered ALU with valid/ready on both sides.
// Single-cycle ops return one cycle after acceptance; with ALU_SEQ_MUL_EN
// defined, opcode A runs an iterative multiply (N+1 cycles), otherwise it is illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input logic     clk_i,
  input logic     rst_ni,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(N);

  alu_state_e     state_q, state_d;
  logic [N-1:0]   s_q, s_d;
  alu_flags_t     fl_q, fl_d;
  logic [N-1:0]   res;
  alu_flags_t     res_fl;
  logic [N:0]     sum;
  logic [SHW-1:0] sh;
  logic           accept;
  logic           is_mul;
  logic           mul_done;
  logic [N-1:0]   mul_prod;

  assign sh            = bus.b_i[SHW-1:0];
  assign bus.in_ready_o = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready_i);
  assign accept        = bus.in_valid_i & bus.in_ready_o;

`ifdef ALU_SEQ_MUL_EN
  assign is_mul = (bus.sel_i == OP_MUL);

  alu_mul_iter #(.N(N)) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(accept & is_mul),
    .a_i    (bus.a_i),
    .b_i    (bus.b_i),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Single-cycle op mux; ADD/SUB go N+1 wide so the top bit is carry/not-borrow.
  always_comb begin
    sum    = '0;
    res    = '0;
    res_fl = '0;
    case (bus.sel_i)
      OP_ADD: begin
        sum      = {1'b0, bus.a_i} + {1'b0, bus.b_i};
        res      = sum[N-1:0];
        res_fl.c = sum[N];
        res_fl.v = (bus.a_i[N-1] == bus.b_i[N-1]) & (sum[N-1] != bus.a_i[N-1]);
      end
      OP_SUB: begin
        sum      = {1'b0, bus.a_i} + {1'b0, ~bus.b_i} + (N+1)'(1);
        res      = sum[N-1:0];
        res_fl.c = sum[N];
        res_fl.v = (bus.a_i[N-1] != bus.b_i[N-1]) & (sum[N-1] != bus.a_i[N-1]);
      end
      OP_AND:  res = bus.a_i & bus.b_i;
      OP_OR:   res = bus.a_i | bus.b_i;
      OP_XOR:  res = bus.a_i ^ bus.b_i;
      OP_SLT:  res = {{(N-1){1'b0}}, $signed(bus.a_i) < $signed(bus.b_i)};
      OP_SLTU: res = {{(N-1){1'b0}}, bus.a_i < bus.b_i};
      OP_SLL:  res = bus.a_i << sh;
      OP_SRL:  res = bus.a_i >> sh;
      OP_SRA:  res = $unsigned($signed(bus.a_i) >>> sh);
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  res = '0;
`endif
      default: res_fl.err = 1'b1;
    endcase
    res_fl.z = (res == '0);
  end

  // FSM: accept from IDLE or from DONE on the same cycle the result is taken.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    fl_d    = fl_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            s_d     = res;
            fl_d    = res_fl;
          end
        end else if ((state_q == DONE) && bus.out_ready_i) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d = DONE;
          s_d     = mul_prod;
          fl_d    = '0;
          fl_d.z  = (mul_prod == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register; outputs only move when a result is loaded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s_q     <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fl_q    <= fl_d;
    end
  end

  assign bus.out_valid_o = (state_q == DONE);
  assign bus.s_o         = s_q;
  assign bus.z_o         = fl_q.z;
  assign bus.c_o         = fl_q.c;
  assign bus.v_o         = fl_q.v;
  assign bus.err_o       = fl_q.err;
endmodule

// File: tb/tb_alu_seq.sv
// Testbench: tb_alu_seq -- directed + random stimulus into alu_seq (N=8),
// results checked against a queue of expected values in output order.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] s;
    logic       z;
    logic       c;
    logic       v;
    logic       err;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  res_t exp_q[$];
  int   hs_cyc[$];

  alu_seq_if #(.N(8)) bus();

  alu_seq #(.N(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [7:0] s, input logic z, input logic c,
                              input logic v, input logic e);
    return {s, z, c, v, e};
  endfunction

  // Reference model written from the opcode definitions, using integer arithmetic.
  function automatic res_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int   sa, sb, t;
    r  = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'h0: begin t = int'(a) + int'(b); r.s = t[7:0]; r.c = t[8];
              r.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      4'h1: begin t = int'(a) - int'(b); r.s = t[7:0]; r.c = (a >= b);
              r.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      4'h2: r.s = a & b;
      4'h3: r.s = a | b;
      4'h4: r.s = a ^ b;
      4'h5: r.s = {7'd0, sa < sb};
      4'h6: r.s = {7'd0, a < b};
      4'h7: r.s = a << b[2:0];
      4'h8: r.s = a >> b[2:0];
      4'h9: r.s = 8'($signed(a) >>> b[2:0]);
`ifdef ALU_SEQ_MUL_EN
      4'hA: begin t = int'(a) * int'(b); r.s = t[7:0]; end
`endif
      default: r.err = 1'b1;
    endcase
    r.z = (r.s == 8'h00);
    return r;
  endfunction

  // Scoreboard: compare on every output handshake (sampled on the falling edge).
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      res_t got;
      res_t e;
      got = {bus.s_o, bus.z_o, bus.c_o, bus.v_o, bus.err_o};
      hs_cyc.push_back(cyc);
      chk("sb_underflow", 32'(exp_q.size() == 0), 32'd0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result{s,z,c,v,err}", 32'(got), 32'(e));
      end
    end
  end

  task automatic send_exp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input res_t e);
    bit ok;
    ok = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.sel_i      = op;
    bus.a_i        = a;
    bus.b_i        = b;
    exp_q.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    send_exp(op, a, b, model(op, a, b));
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.sel_i       = '0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.out_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_s", 32'(bus.s_o), 32'd0);
    chk("rst_flags", 32'({bus.z_o, bus.c_o, bus.v_o, bus.err_o}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);

    // Arithmetic, compare and shift corner cases
    send_exp(OP_ADD,  8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    send_exp(OP_ADD,  8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b0));
    send_exp(OP_SUB,  8'h05, 8'h05, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    send_exp(OP_SUB,  8'h03, 8'h05, mk(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0));
    send_exp(OP_SUB,  8'h80, 8'h01, mk(8'h7F, 1'b0, 1'b1, 1'b1, 1'b0));
    send_exp(OP_SLT,  8'hFF, 8'h01, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    send_exp(OP_SLTU, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    send_exp(OP_SRA,  8'h80, 8'h03, mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0));
    send_exp(OP_SRL,  8'h80, 8'h03, mk(8'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    send_exp(OP_SLL,  8'h01, 8'h09, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    send_exp(OP_XOR,  8'hA5, 8'hA5, mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    send_exp(4'hF,    8'h12, 8'h34, mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
`ifndef ALU_SEQ_MUL_EN
    send_exp(4'hA,    8'h0C, 8'h0B, mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
`endif
    drain();

    // Random ops, all opcodes including illegal ones
    for (int i = 0; i < 24; i++) begin
      send(4'($urandom_range(15)), 8'($urandom), 8'($urandom));
    end
    drain();

    // Back-to-back: four results on four consecutive cycles
    send(OP_ADD, 8'h10, 8'h20);
    send(OP_OR,  8'h0F, 8'hF0);
    send(OP_SUB, 8'h01, 8'h02);
    send(OP_SLL, 8'h03, 8'h04);
    drain();
    chk("b2b_span", 32'(hs_cyc[$] - hs_cyc[$-3]), 32'd3);

    // Output stall: result held, input blocked, waiting op accepted afterwards
    bus.out_ready_i = 1'b0;
    send(OP_XOR, 8'h5A, 8'h0F);
    bus.in_valid_i = 1'b1;
    bus.sel_i      = OP_OR;
    bus.a_i        = 8'h30;
    bus.b_i        = 8'h03;
    exp_q.push_back(mk(8'h33, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid_o), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready_o), 32'd0);
      chk("stall_s", 32'(bus.s_o), 32'h55);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    drain();

`ifdef ALU_SEQ_MUL_EN
    // Multiply latency and input stall
    begin
      int lat;
      bit busy_ok;
      lat     = 0;
      busy_ok = 1'b1;
      bus.in_valid_i = 1'b1;
      bus.sel_i      = OP_MUL;
      bus.a_i        = 8'h0C;
      bus.b_i        = 8'h0B;
      exp_q.push_back(mk(8'h84, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      while (!bus.out_valid_o && lat < 40) begin
        if (bus.in_ready_o) busy_ok = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
      chk("mul_latency", 32'(lat), 32'd9);
      chk("mul_in_ready_low", 32'(busy_ok), 32'd1);
    end
    drain();
    send_exp(OP_MUL, 8'hFF, 8'hFF, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    send(OP_MUL, 8'h10, 8'h10);
    send(OP_ADD, 8'h01, 8'h01);
    drain();
`endif

    // Asynchronous reset mid-cycle while a result is held
    bus.out_ready_i = 1'b0;
    send_exp(OP_OR, 8'hA0, 8'h05, mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("async_rst_s", 32'(bus.s_o), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);

`ifdef ALU_SEQ_MUL_EN
    // Reset three cycles into a multiply
    send_exp(OP_XOR, 8'hFF, 8'h00, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();
    send_exp(OP_MUL, 8'h0C, 8'h0B, mk(8'h84, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mul_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("mul_rst_s", 32'(bus.s_o), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mul_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
`endif

    send_exp(OP_AND, 8'hF0, 8'h3C, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();
    repeat (12) @(posedge clk);
    #1;
    chk("idle_no_spurious", 32'(bus.out_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
